filtro_peso: RTL and testbench

FILTRO_PESO -- requirements
Module: filtro_peso

---
 rtl/filtro_peso.sv | 130 +++++++++++++
 tb/tb_filtro_peso.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/filtro_peso.sv
// Load-cell filter: moving average over 2^N_LOG2 samples, tare offset, overload
// clamp and settling detector. One output pulse per accepted sample once the window is full.
module filtro_peso #(
    parameter int          N_LOG2    = 2,
    parameter int          LIMIAR    = 8,
    parameter int          N_ESTAVEL = 16,
    parameter logic [31:0] PESO_MAX  = 32'd5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] amostra,
    input  logic        amostra_valida,
    input  logic        tara,
    output logic [31:0] peso,
    output logic        peso_valido,
    output logic        estavel,
    output logic        sobrecarga
);

    localparam int JAN    = 1 << N_LOG2;
    localparam int SW     = 24 + N_LOG2;
    localparam int CW     = $clog2(N_ESTAVEL + 1);
    localparam int STAGES = 1;

    localparam logic [1:0] ENCHER = 2'd0;
    localparam logic [1:0] MEDIR  = 2'd1;
    localparam logic [1:0] TARAR  = 2'd2;

    logic [JAN-1:0][23:0] janela;
    logic [SW-1:0]        soma, soma_nova;
    logic [23:0]          media_nova, media, media_ant, offset, dif;
    logic [N_LOG2:0]      n_cheio;
    logic [1:0]           estado;
    logic                 pend, completa, emite, captura, capt_q;
    logic [STAGES:0]      vld_pipe;
    logic [CW-1:0]        cnt_est, cnt_prox;
    logic [24:0]          liquido;

    always_comb begin
        soma_nova  = soma + SW'(amostra) - SW'(janela[JAN-1]);
        media_nova = 24'(soma_nova >> N_LOG2);
        completa   = (estado == ENCHER) && (n_cheio == (N_LOG2+1)'(JAN - 1));
        emite      = amostra_valida && ((estado != ENCHER) || completa);
        // a tare arriving with the strobe is honoured by that same strobe
        captura    = emite && (pend || tara);
    end

    // stage 1: window, running sum, fill count, FSM, tare flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            janela      <= '0;
            soma        <= '0;
            n_cheio     <= '0;
            estado      <= ENCHER;
            pend        <= 1'b0;
            media       <= '0;
            capt_q      <= 1'b0;
            vld_pipe[0] <= 1'b0;
        end else begin
            vld_pipe[0] <= emite;
            capt_q      <= captura;
            if (emite) media <= media_nova;
            if (amostra_valida) begin
                soma <= soma_nova;
                for (int i = JAN - 1; i > 0; i--) janela[i] <= janela[i-1];
                janela[0] <= amostra;
            end
            if (captura)   pend <= 1'b0;
            else if (tara) pend <= 1'b1;
            case (estado)
                ENCHER: if (amostra_valida) begin
                    n_cheio <= n_cheio + 1'b1;
                    if (completa) estado <= MEDIR;
                end
                MEDIR:   if (pend && !amostra_valida) estado <= TARAR;
                TARAR:   if (amostra_valida) estado <= MEDIR;
                default: estado <= ENCHER;
            endcase
        end
    end

    always_comb begin
        liquido  = {1'b0, media} - {1'b0, offset};
        dif      = (media >= media_ant) ? (media - media_ant) : (media_ant - media);
        cnt_prox = '0;
        if (dif <= 24'(LIMIAR))
            cnt_prox = (cnt_est == CW'(N_ESTAVEL)) ? cnt_est : cnt_est + 1'b1;
    end

    // stage 2: net weight, clamp, stability; outputs move only with peso_valido
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[STAGES] <= 1'b0;
            peso       <= '0;
            sobrecarga <= 1'b0;
            estavel    <= 1'b0;
            offset     <= '0;
            media_ant  <= '0;
            cnt_est    <= '0;
        end else begin
            vld_pipe[STAGES] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                media_ant <= media;
                if (capt_q) begin
                    offset     <= media;
                    peso       <= '0;
                    sobrecarga <= 1'b0;
                    cnt_est    <= '0;
                    estavel    <= 1'b0;
                end else begin
                    cnt_est <= cnt_prox;
                    estavel <= (cnt_prox == CW'(N_ESTAVEL));
                    if (liquido[24]) begin
                        peso       <= '0;
                        sobrecarga <= 1'b0;
                    end else if ({8'd0, liquido[23:0]} > PESO_MAX) begin
                        peso       <= PESO_MAX;
                        sobrecarga <= 1'b1;
                    end else begin
                        peso       <= {8'd0, liquido[23:0]};
                        sobrecarga <= 1'b0;
                    end
                end
            end
        end
    end

    assign peso_valido = vld_pipe[STAGES];

endmodule

// File: tb/tb_filtro_peso.sv
// Bench for filtro_peso: directed scenarios then random traffic, all checked
// against a window/queue model of the filter.
module tb_filtro_peso;

    localparam int          NL   = 2;
    localparam int          JAN  = 1 << NL;
    localparam int          LIM  = 8;
    localparam int          NE   = 16;
    localparam logic [31:0] PMAX = 32'd5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] amostra = '0;
    logic        amostra_valida = 1'b0;
    logic        tara = 1'b0;
    logic [31:0] peso;
    logic        peso_valido, estavel, sobrecarga;

    filtro_peso #(.N_LOG2(NL), .LIMIAR(LIM), .N_ESTAVEL(NE), .PESO_MAX(PMAX)) dut (
        .clk(clk), .rst(rst), .amostra(amostra), .amostra_valida(amostra_valida),
        .tara(tara), .peso(peso), .peso_valido(peso_valido), .estavel(estavel),
        .sobrecarga(sobrecarga)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        int unsigned peso;
        bit          sob;
        bit          est;
    } out_t;

    int unsigned win[$];
    longint      m_off, m_prev;
    int          m_cnt;
    bit          m_pend;
    out_t        nxt, cur, last;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_off = 0; m_prev = 0; m_cnt = 0; m_pend = 0;
        nxt = '{0, 0, 0, 0};
        last = '{0, 0, 0, 0};
    endtask

    // Window average straight from the list of the last JAN samples.
    task automatic model_accept(int unsigned a);
        longint s, avg, net;
        win.push_back(a);
        if (win.size() > JAN) void'(win.pop_front());
        if (win.size() == JAN) begin
            s = 0;
            foreach (win[i]) s += win[i];
            avg = s / JAN;
            nxt.v = 1;
            if (m_pend) begin
                m_pend = 0;
                m_off = avg;
                m_cnt = 0;
                nxt.peso = 0; nxt.sob = 0; nxt.est = 0;
            end else begin
                net = avg - m_off;
                if (net < 0) begin nxt.peso = 0; nxt.sob = 0; end
                else if (net > longint'(PMAX)) begin nxt.peso = PMAX; nxt.sob = 1; end
                else begin nxt.peso = int'(net); nxt.sob = 0; end
                if ((avg > m_prev ? avg - m_prev : m_prev - avg) <= LIM)
                    m_cnt = (m_cnt < NE) ? m_cnt + 1 : NE;
                else
                    m_cnt = 0;
                nxt.est = (m_cnt == NE);
            end
            m_prev = avg;
        end
    endtask

    task automatic step(bit v, int unsigned a, bit t, string tag);
        @(negedge clk);
        amostra_valida = v; amostra = a[23:0]; tara = t;
        @(posedge clk);
        cur = nxt;
        nxt.v = 0;
        if (t) m_pend = 1;
        if (v) model_accept(a);
        #1;
        amostra_valida = 0; tara = 0;
        chk({tag, ".valido"}, {31'd0, peso_valido}, {31'd0, cur.v});
        if (cur.v) last = cur;
        chk({tag, ".peso"}, peso, last.peso);
        chk({tag, ".sobrecarga"}, {31'd0, sobrecarga}, {31'd0, last.sob});
        chk({tag, ".estavel"}, {31'd0, estavel}, {31'd0, last.est});
    endtask

    // Reset is raised between edges so the outputs must clear without a clock.
    task automatic pulse_reset(string tag);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk({tag, ".peso"}, peso, 32'd0);
        chk({tag, ".valido"}, {31'd0, peso_valido}, 32'd0);
        chk({tag, ".estavel"}, {31'd0, estavel}, 32'd0);
        chk({tag, ".sobrecarga"}, {31'd0, sobrecarga}, 32'd0);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    initial begin
        int unsigned base;
        model_reset();
        pulse_reset("reset");

        for (int i = 0; i < 4; i++) step(1, 1000, 0, "fill1000");
        step(0, 0, 0, "fill1000.out");

        for (int i = 0; i < 3; i++) step(1, 1000, 0, "steady");
        step(1, 1000, 1, "tara_same");
        for (int i = 0; i < 4; i++) step(1, 1500, 0, "ramp1500");
        step(0, 0, 0, "ramp.out");

        for (int i = 0; i < 4; i++) step(1, 2000, 0, "to2000");
        step(0, 0, 1, "tara_alone");
        step(0, 0, 1, "tara_again");
        step(0, 0, 0, "tara_wait");
        step(1, 2000, 0, "tara_cap");
        for (int i = 0; i < 4; i++) step(1, 1000, 0, "neg_clamp");
        step(0, 0, 0, "neg.out");

        pulse_reset("reset2");
        for (int i = 0; i < 8; i++) step(1, 8000, 0, "over8000");
        for (int i = 0; i < 4; i++) step(1, 100, 0, "under100");
        step(0, 0, 0, "under.out");

        pulse_reset("reset3");
        for (int i = 0; i < 20; i++) step(1, (i % 2) ? 1004 : 1000, 0, "alt");
        step(0, 0, 0, "alt.out");
        step(1, 1100, 0, "jump1100");
        step(0, 0, 0, "jump.out");

        pulse_reset("reset4");
        step(1, 500, 0, "midfill");
        step(1, 500, 1, "midfill_tara");
        pulse_reset("reset_midfill");
        for (int i = 0; i < 3; i++) step(1, 700, 0, "refill");
        step(1, 700, 1, "refill_tara_last");
        step(1, 900, 0, "after_refill");
        step(0, 0, 0, "after.out");

        base = 3000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0)
                case ($urandom_range(0, 3))
                    0: base = 0;
                    1: base = 3000;
                    2: base = 9000;
                    default: base = 16777000;
                endcase
            if (i == 200) pulse_reset("reset_rand");
            step($urandom_range(0, 3) != 0, base + $urandom_range(0, 12),
                 $urandom_range(0, 24) == 0, "rand");
        end
        step(0, 0, 0, "rand.out");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
